laser_pulse_sequencer: RTL

Downstream consumer of the frame clock divider in the two-color laser controller: takes the divided frame-rate square wave, detects its rising edges, and after a programmable dead time fires one laser pulse of programmable width per frame. Pulses alternate between laser A and laser B, or stay on one color, according to a mode input. The block also keeps a frame counter and a sticky overrun flag for the host.

---
 rtl/laser_pulse_sequencer_if.sv | 29 ++
 rtl/laser_pulse_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/laser_pulse_sequencer_if.sv
// Host-side bundle for the laser pulse sequencer: frame input, timing configuration
// and the laser drive / status outputs.
interface laser_pulse_sequencer_if #(
   parameter int CNT_W   = 28,
   parameter int FRAME_W = 16
);
   logic               frame_sync;
   logic               enable;
   logic [1:0]         mode;
   logic [CNT_W-1:0]   dead_time;
   logic [CNT_W-1:0]   pulse_width;
   logic               clear_overrun;
   logic               laser_a;
   logic               laser_b;
   logic               color_sel;
   logic               busy;
   logic [FRAME_W-1:0] frame_count;
   logic               overrun;

   modport master (
      output frame_sync, enable, mode, dead_time, pulse_width, clear_overrun,
      input  laser_a, laser_b, color_sel, busy, frame_count, overrun
   );

   modport slave (
      input  frame_sync, enable, mode, dead_time, pulse_width, clear_overrun,
      output laser_a, laser_b, color_sel, busy, frame_count, overrun
   );
endinterface

// File: rtl/laser_pulse_sequencer.sv
// Fires one programmable laser pulse per frame-sync rising edge after a programmable
// dead time, alternating or fixing the laser color, with frame counting and overrun status.
module laser_pulse_sequencer #(
   parameter int CNT_W   = 28,
   parameter int FRAME_W = 16
) (
   input  logic                   clock_in,
   input  logic                   reset_n,
   laser_pulse_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_PULSE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]   TIMER_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   TIMER_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [FRAME_W-1:0] FRAME_ZERO = {FRAME_W{1'b0}};
   localparam logic [FRAME_W-1:0] FRAME_ONE  = {{(FRAME_W-1){1'b0}}, 1'b1};

   state_t             state_r;
   logic               sync_prev_r;
   logic [CNT_W-1:0]   timer_r;
   logic [CNT_W-1:0]   pulse_width_r;
   logic [1:0]         mode_r;
   logic               laser_a_r;
   logic               laser_b_r;
   logic               color_sel_r;
   logic               busy_r;
   logic [FRAME_W-1:0] frame_count_r;
   logic               overrun_r;

   logic               frame_edge_s;
   logic               accept_s;
   logic               drop_s;

   // Returns {laser_b, laser_a} for a pulse under the given mode and color.
   function automatic logic [1:0] laser_select(input logic [1:0] sel_mode, input logic color);
      logic [1:0] lasers;
      case (sel_mode)
         2'd0:    lasers = color ? 2'b10 : 2'b01;
         2'd1:    lasers = 2'b01;
         2'd2:    lasers = 2'b10;
         default: lasers = 2'b00;
      endcase
      return lasers;
   endfunction

   function automatic logic next_color(input logic [1:0] sel_mode, input logic color);
      return (sel_mode == 2'd0) ? ~color : color;
   endfunction

   // Frame edge classification: accepted when idle, dropped (overrun) when busy.
   always_comb begin
      frame_edge_s = bus.frame_sync & ~sync_prev_r;
      accept_s     = frame_edge_s & bus.enable & (state_r == ST_IDLE);
      drop_s       = frame_edge_s & bus.enable & (state_r != ST_IDLE);
   end

   // Sequencer FSM: configuration latch, dead/pulse timers, laser drive and frame count.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         sync_prev_r   <= 1'b0;
         timer_r       <= TIMER_ZERO;
         pulse_width_r <= TIMER_ZERO;
         mode_r        <= 2'd0;
         laser_a_r     <= 1'b0;
         laser_b_r     <= 1'b0;
         color_sel_r   <= 1'b0;
         busy_r        <= 1'b0;
         frame_count_r <= FRAME_ZERO;
      end else begin
         sync_prev_r <= bus.frame_sync;
         if (!bus.enable) begin
            // Abort: lasers off and back to idle; color and count are left untouched.
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            laser_a_r <= 1'b0;
            laser_b_r <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (accept_s) begin
                     frame_count_r <= frame_count_r + FRAME_ONE;
                     mode_r        <= bus.mode;
                     pulse_width_r <= bus.pulse_width;
                     if (bus.dead_time != TIMER_ZERO) begin
                        state_r <= ST_DELAY;
                        busy_r  <= 1'b1;
                        timer_r <= bus.dead_time;
                     end else if (bus.pulse_width != TIMER_ZERO) begin
                        state_r                <= ST_PULSE;
                        busy_r                 <= 1'b1;
                        timer_r                <= bus.pulse_width;
                        {laser_b_r, laser_a_r} <= laser_select(bus.mode, color_sel_r);
                     end else begin
                        color_sel_r <= next_color(bus.mode, color_sel_r);
                     end
                  end
               end
               ST_DELAY: begin
                  if (timer_r == TIMER_ONE) begin
                     if (pulse_width_r != TIMER_ZERO) begin
                        state_r                <= ST_PULSE;
                        timer_r                <= pulse_width_r;
                        {laser_b_r, laser_a_r} <= laser_select(mode_r, color_sel_r);
                     end else begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        color_sel_r <= next_color(mode_r, color_sel_r);
                     end
                  end else begin
                     timer_r <= timer_r - TIMER_ONE;
                  end
               end
               ST_PULSE: begin
                  if (timer_r == TIMER_ONE) begin
                     state_r     <= ST_IDLE;
                     busy_r      <= 1'b0;
                     laser_a_r   <= 1'b0;
                     laser_b_r   <= 1'b0;
                     color_sel_r <= next_color(mode_r, color_sel_r);
                  end else begin
                     timer_r <= timer_r - TIMER_ONE;
                  end
               end
               default: begin
                  state_r   <= ST_IDLE;
                  busy_r    <= 1'b0;
                  laser_a_r <= 1'b0;
                  laser_b_r <= 1'b0;
               end
            endcase
         end
      end
   end

   // Sticky overrun flag; a new overrun outranks a simultaneous clear.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         overrun_r <= 1'b0;
      end else if (drop_s) begin
         overrun_r <= 1'b1;
      end else if (bus.clear_overrun) begin
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= overrun_r;
      end
   end

   assign bus.laser_a     = laser_a_r;
   assign bus.laser_b     = laser_b_r;
   assign bus.color_sel   = color_sel_r;
   assign bus.busy        = busy_r;
   assign bus.frame_count = frame_count_r;
   assign bus.overrun     = overrun_r;
endmodule
